// File: rtl/rr_stream_mux_if.sv
// rr_stream_mux_if: N:1 stream mux handshake bundle.
//   slave  - mux view (consumes input streams, produces the merged stream)
//   master - environment view (producers plus consumer)
interface rr_stream_mux_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 32,
    parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N:1 valid/ready stream mux with internal arbiter and a
// registered output stage (1-cycle latency, full throughput).
// Config macro: RR_STREAM_MUX_FIXED_PRIO_EN -- when defined, the arbiter is
// fixed priority (lowest index wins) and the round-robin pointer is dropped.
module rr_stream_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 32,
    parameter int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input logic           clock,
    input logic           reset_n,
    rr_stream_mux_if.slave bus
);
    logic                         ld;
    logic                         any_v;
    logic [SEL_W-1:0]             g;
    logic [NUM_IN-1:0][WIDTH-1:0] words;

    // Output register can take a new word when empty or draining this cycle
    assign ld    = !bus.out_valid || bus.out_ready;
    assign any_v = |bus.in_valid;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_lane
        assign words[k] = bus.in_data[k*WIDTH +: WIDTH];
    end

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
    // Fixed priority: descending scan so the lowest valid index wins
    always_comb begin
        g = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (bus.in_valid[SEL_W'(k)]) g = SEL_W'(k);
        end
    end
`else
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] g_hi, g_lo;
    logic             hit_hi;

    // Round-robin: lowest valid index above ptr, else wrap to lowest index <= ptr
    always_comb begin
        g_hi   = '0;
        g_lo   = '0;
        hit_hi = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            if (bus.in_valid[SEL_W'(k)]) begin
                if (SEL_W'(k) > ptr) begin
                    g_hi   = SEL_W'(k);
                    hit_hi = 1'b1;
                end else begin
                    g_lo = SEL_W'(k);
                end
            end
        end
        g = hit_hi ? g_hi : g_lo;
    end

    // Pointer follows the last grant; reset leaves channel 0 first in line
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            ptr <= SEL_W'(NUM_IN - 1);
        else if (ld && any_v)
            ptr <= g;
    end
`endif

    // One-hot accept to the winner; held off while in reset so nothing is lost
    always_comb begin
        bus.in_ready = '0;
        if (ld && any_v && reset_n) bus.in_ready[g] = 1'b1;
    end

    // Output stage: load the winner, go empty on an idle load, hold on stall
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
        end else if (ld) begin
            if (any_v) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= words[g];
                bus.out_sel   <= g;
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed vectors for rr_stream_mux at default parameters.
module tb_rr_stream_mux;
    localparam int WIDTH  = 32;
    localparam int NUM_IN = 32;
    localparam int SEL_W  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    rr_stream_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

    rr_stream_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_data_idx();
        for (int k = 0; k < NUM_IN; k++) bus.in_data[k*WIDTH +: WIDTH] = WIDTH'(k);
    endtask

    function automatic logic [NUM_IN-1:0] oh(input int k);
        logic [NUM_IN-1:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Reset for one cycle with every channel valid: outputs cleared, no accepts
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        set_data_idx();
        bus.in_valid = '1;
        #1;
        chk("rst_ovalid", 64'(bus.out_valid), 64'd0);
        chk("rst_odata",  64'(bus.out_data),  64'd0);
        chk("rst_osel",   64'(bus.out_sel),   64'd0);
        chk("rst_iready", 64'(bus.in_ready),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e;
        bus.in_data   = '0;
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;

        // 1: all channels valid, data=k -> 0..31 then wrap to 0
        do_reset();
        bus.in_valid = '1;
        #1;
        chk("t1_iready0", 64'(bus.in_ready), 64'(oh(0)));
        for (int n = 0; n < 34; n++) begin
            @(negedge clk);
            chk("t1_ovalid", 64'(bus.out_valid), 64'd1);
            chk("t1_odata",  64'(bus.out_data),  64'(n % 32));
            chk("t1_osel",   64'(bus.out_sel),   64'(bus.out_data[4:0]));
            chk("t1_iready", 64'(bus.in_ready),  64'(oh((n + 1) % 32)));
        end

        // 2: channels 3 and 7 alternate
        do_reset();
        bus.in_valid = oh(3) | oh(7);
        for (int i = 0; i < 4; i++) begin
            e = (i % 2 == 0) ? 3 : 7;
            #1;
            chk("t2_iready", 64'(bus.in_ready), 64'(oh(e)));
            @(negedge clk);
            chk("t2_odata", 64'(bus.out_data), 64'(e));
            chk("t2_osel",  64'(bus.out_sel),  64'(e));
        end

        // 3: word 5 stalled for 4 cycles, then drained and replaced
        do_reset();
        bus.in_valid = oh(5);
        @(negedge clk);
        chk("t3_load", 64'(bus.out_data), 64'd5);
        bus.out_ready = 1'b0;
        bus.in_data[5*WIDTH +: WIDTH] = 32'h55;
        #1;
        chk("t3_iready_stall", 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_hold_data",  64'(bus.out_data),  64'd5);
            chk("t3_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("t3_hold_irdy",  64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t3_iready_rel", 64'(bus.in_ready), 64'(oh(5)));
        @(negedge clk);
        chk("t3_next", 64'(bus.out_data), 64'h55);
        bus.in_valid = '0;

        // 4: single one-cycle word -> one-cycle out_valid, data held after
        do_reset();
        bus.in_data[9*WIDTH +: WIDTH] = 32'h99;
        bus.in_valid = oh(9);
        @(negedge clk);
        chk("t4_valid1", 64'(bus.out_valid), 64'd1);
        chk("t4_data1",  64'(bus.out_data),  64'h99);
        bus.in_valid = '0;
        @(negedge clk);
        chk("t4_valid0", 64'(bus.out_valid), 64'd0);
        chk("t4_dhold",  64'(bus.out_data),  64'h99);
        chk("t4_shold",  64'(bus.out_sel),   64'd9);
        @(negedge clk);
        chk("t4_valid0b", 64'(bus.out_valid), 64'd0);

        // 5: asynchronous reset mid-stream, then restart at lowest valid
        do_reset();
        bus.in_valid = '1;
        repeat (3) @(negedge clk);
        chk("t5_pre_valid", 64'(bus.out_valid), 64'd1);
        chk("t5_pre_data",  64'(bus.out_data),  64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_async_data",  64'(bus.out_data),  64'd0);
        chk("t5_async_irdy",  64'(bus.in_ready),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = oh(4) | oh(6);
        #1;
        chk("t5_first_irdy", 64'(bus.in_ready), 64'(oh(4)));
        @(negedge clk);
        chk("t5_first_sel", 64'(bus.out_sel), 64'd4);

        // 6: channels 2 and 9 held valid
        do_reset();
        bus.in_valid = oh(2) | oh(9);
        for (int i = 0; i < 4; i++) begin
`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
            e = 2;
`else
            e = (i % 2 == 0) ? 2 : 9;
`endif
            #1;
            chk("t6_iready", 64'(bus.in_ready), 64'(oh(e)));
            @(negedge clk);
            chk("t6_osel", 64'(bus.out_sel), 64'(e));
        end
        bus.in_valid = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
